gen_tm_multi: RTL and testbench

Multi-channel measurement-window generator for the clock-enable timing chain. It is the parametrised successor of the single-channel fixed-length Tm generator. Each channel opens a window Tm of programmable length, counted in Tce ticks, after a start request. Added over the single-channel block: one-shot or periodic mode, a programmable gap between windows, abort, a done pulse, and per-channel lengths latched at start.

---
 rtl/gen_tm_multi.sv | 171 +++++++++++++++++
 tb/tb_gen_tm_multi.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_tm_multi.sv
// gen_tm_multi: NCH independent Tce-counted measurement-window generators.
// Build macro GEN_TM_RETRIG_EN lets st restart a running window in place.
module gen_tm_multi #(
   parameter int NCH = 4,
   parameter int LW  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ce,
   input  logic [NCH-1:0]    st,
   input  logic [NCH-1:0]    abort,
   input  logic [NCH-1:0]    mode,
   input  logic [NCH*LW-1:0] len,
   input  logic [NCH*LW-1:0] gap,
   output logic [NCH-1:0]    Tm,
   output logic [NCH-1:0]    done,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_ACTIVE,
      S_GAP
   } state_t;

   state_t         r_state    [NCH];
   state_t         w_state_nx [NCH];
   logic [LW-1:0]  r_cnt      [NCH];
   logic [LW-1:0]  w_cnt_nx   [NCH];
   logic [LW-1:0]  r_len      [NCH];
   logic [LW-1:0]  w_len_nx   [NCH];
   logic [LW-1:0]  r_gap      [NCH];
   logic [LW-1:0]  w_gap_nx   [NCH];
   logic [LW-1:0]  w_len_in   [NCH];
   logic [LW-1:0]  w_gap_in   [NCH];
   logic [NCH-1:0] r_mode;
   logic [NCH-1:0] w_mode_nx;
   logic [NCH-1:0] r_tm;
   logic [NCH-1:0] w_tm_nx;
   logic [NCH-1:0] r_done;
   logic [NCH-1:0] w_done_nx;
   logic           w_busy;

   for (genvar gi = 0; gi < NCH; gi++) begin : g_slice
      assign w_len_in[gi] = len[gi*LW +: LW];
      assign w_gap_in[gi] = gap[gi*LW +: LW];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            r_state[i] <= S_IDLE;
            r_cnt[i]   <= '0;
            r_len[i]   <= '0;
            r_gap[i]   <= '0;
         end
         r_mode <= '0;
         r_tm   <= '0;
         r_done <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            r_state[i] <= w_state_nx[i];
            r_cnt[i]   <= w_cnt_nx[i];
            r_len[i]   <= w_len_nx[i];
            r_gap[i]   <= w_gap_nx[i];
         end
         r_mode <= w_mode_nx;
         r_tm   <= w_tm_nx;
         r_done <= w_done_nx;
      end
   end

   always_comb begin
      w_mode_nx = r_mode;
      w_tm_nx   = r_tm;
      w_done_nx = '0;
      for (int i = 0; i < NCH; i++) begin
         w_state_nx[i] = r_state[i];
         w_cnt_nx[i]   = r_cnt[i];
         w_len_nx[i]   = r_len[i];
         w_gap_nx[i]   = r_gap[i];
         if (abort[i]) begin
            w_state_nx[i] = S_IDLE;
            w_cnt_nx[i]   = '0;
            w_tm_nx[i]    = 1'b0;
`ifdef GEN_TM_RETRIG_EN
         end else if (st[i] && (r_state[i] == S_ACTIVE ||
                                r_state[i] == S_GAP)) begin
            w_len_nx[i]  = w_len_in[i];
            w_gap_nx[i]  = w_gap_in[i];
            w_mode_nx[i] = mode[i];
            if (w_len_in[i] == '0) begin
               w_state_nx[i] = S_IDLE;
               w_cnt_nx[i]   = '0;
               w_tm_nx[i]    = 1'b0;
               w_done_nx[i]  = 1'b1;
            end else begin
               w_state_nx[i] = S_ACTIVE;
               w_cnt_nx[i]   = w_len_in[i];
               w_tm_nx[i]    = 1'b1;
            end
`endif
         end else begin
            unique case (r_state[i])
               S_IDLE: begin
                  if (st[i]) begin
                     if (w_len_in[i] == '0) begin
                        w_done_nx[i] = 1'b1;
                     end else begin
                        w_len_nx[i]   = w_len_in[i];
                        w_gap_nx[i]   = w_gap_in[i];
                        w_mode_nx[i]  = mode[i];
                        w_state_nx[i] = S_ARM;
                     end
                  end
               end
               S_ARM: begin
                  if (ce) begin
                     w_state_nx[i] = S_ACTIVE;
                     w_cnt_nx[i]   = r_len[i];
                     w_tm_nx[i]    = 1'b1;
                  end
               end
               S_ACTIVE: begin
                  if (ce) begin
                     if (r_cnt[i] != LW'(1)) begin
                        w_cnt_nx[i] = r_cnt[i] - LW'(1);
                     end else if (!r_mode[i]) begin
                        w_state_nx[i] = S_IDLE;
                        w_cnt_nx[i]   = '0;
                        w_tm_nx[i]    = 1'b0;
                        w_done_nx[i]  = 1'b1;
                     end else if (r_gap[i] != '0) begin
                        w_state_nx[i] = S_GAP;
                        w_cnt_nx[i]   = r_gap[i];
                        w_tm_nx[i]    = 1'b0;
                     end else begin
                        // zero gap: reload without dropping Tm
                        w_cnt_nx[i] = r_len[i];
                     end
                  end
               end
               S_GAP: begin
                  if (ce) begin
                     if (r_cnt[i] != LW'(1)) begin
                        w_cnt_nx[i] = r_cnt[i] - LW'(1);
                     end else begin
                        w_state_nx[i] = S_ACTIVE;
                        w_cnt_nx[i]   = r_len[i];
                        w_tm_nx[i]    = 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end

   always_comb begin
      w_busy = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         w_busy = w_busy | (r_state[i] != S_IDLE);
      end
   end

   assign Tm   = r_tm;
   assign done = r_done;
   assign busy = w_busy;

endmodule

// File: tb/tb_gen_tm_multi.sv
// Self-checking bench for gen_tm_multi: directed scenarios plus random
// traffic against a ce-tick-counting window model.
module tb_gen_tm_multi;

   localparam int NCH = 4;
   localparam int LW  = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              ce;
   logic [NCH-1:0]    st;
   logic [NCH-1:0]    abort;
   logic [NCH-1:0]    mode;
   logic [NCH*LW-1:0] len;
   logic [NCH*LW-1:0] gap;
   logic [NCH-1:0]    Tm;
   logic [NCH-1:0]    done;
   logic              busy;

   int n_vec = 0;
   int n_err = 0;

   // model: a running channel counts ce ticks k since it was armed
   bit             m_act  [NCH];
   int             m_k    [NCH];
   int             m_len  [NCH];
   int             m_gap  [NCH];
   bit             m_mode [NCH];
   logic [NCH-1:0] m_done = '0;

   gen_tm_multi #(.NCH(NCH), .LW(LW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (ce),
      .st    (st),
      .abort (abort),
      .mode  (mode),
      .len   (len),
      .gap   (gap),
      .Tm    (Tm),
      .done  (done),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [NCH-1:0] exp_tm();
      logic [NCH-1:0] t;
      t = '0;
      for (int c = 0; c < NCH; c++) begin
         if (m_act[c] && m_k[c] >= 1) begin
            if (m_mode[c])
               t[c] = ((m_k[c] - 1) % (m_len[c] + m_gap[c])) < m_len[c];
            else
               t[c] = (m_k[c] <= m_len[c]);
         end
      end
      return t;
   endfunction

   function automatic logic exp_busy();
      logic b;
      b = 1'b0;
      for (int c = 0; c < NCH; c++) b = b | m_act[c];
      return b;
   endfunction

   task automatic step();
      int sl;
      m_done = '0;
      for (int c = 0; c < NCH; c++) begin
         sl = int'(len[c*LW +: LW]);
         if (!rst_n) begin
            m_act[c] = 0; m_k[c] = 0; m_len[c] = 0;
            m_gap[c] = 0; m_mode[c] = 0;
         end else if (abort[c]) begin
            m_act[c] = 0; m_k[c] = 0;
         end else if (!m_act[c]) begin
            if (st[c]) begin
               if (sl == 0) m_done[c] = 1'b1;
               else begin
                  m_act[c] = 1; m_k[c] = 0; m_len[c] = sl;
                  m_gap[c] = int'(gap[c*LW +: LW]);
                  m_mode[c] = mode[c];
               end
            end
`ifdef GEN_TM_RETRIG_EN
         end else if (st[c] && m_k[c] >= 1) begin
            m_len[c] = sl; m_gap[c] = int'(gap[c*LW +: LW]);
            m_mode[c] = mode[c];
            if (sl == 0) begin
               m_act[c] = 0; m_k[c] = 0; m_done[c] = 1'b1;
            end else m_k[c] = 1;
`endif
         end else if (ce) begin
            m_k[c]++;
            if (!m_mode[c] && m_k[c] == m_len[c] + 1) begin
               m_act[c] = 0; m_k[c] = 0; m_done[c] = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ce = 0; st = '0; abort = '0; mode = '0; len = '0; gap = '0;
   endtask

   task automatic set_ch(input int c, input int l, input int g, input bit m);
      len[c*LW +: LW] = LW'(l);
      gap[c*LW +: LW] = LW'(g);
      mode[c] = m;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 0;
      step(); step();
      n_vec++;
      if ({Tm, done, busy} !== '0) begin
         n_err++;
         $display("FAIL reset_state got=%b exp=0", {Tm, done, busy});
      end
      rst_n = 1;
      set_ch(0, 5, 0, 0);
      st[0] = 1; step(); st = '0;
      ce = 1; step(); step();
      rst_n = 0; step(); rst_n = 1;
      n_vec++;
      if ({Tm, done, busy} !== '0) begin
         n_err++;
         $display("FAIL reset_mid got=%b exp=0", {Tm, done, busy});
      end
      for (int i = 0; i < 8; i++) begin
         step();
         n_vec++;
         if ({Tm, done, busy} !== '0 ||
             {Tm, done, busy} !== {exp_tm(), m_done, exp_busy()}) begin
            n_err++;
            $display("FAIL reset_after c%0d got=%b exp=0", i, {Tm, done, busy});
         end
      end
      ce = 0;
   endtask

   task automatic test_oneshot();
      int hi, dn;
      clear_inputs();
      hi = 0; dn = 0;
      set_ch(0, 3, 0, 0);
      st[0] = 1; step(); st = '0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         ce = (cyc % 4 == 3);
         step();
         hi += int'(Tm[0]);
         dn += int'(done[0]);
         n_vec++;
         if ({Tm, done, busy} !== {exp_tm(), m_done, exp_busy()}) begin
            n_err++;
            $display("FAIL oneshot c%0d got=%b exp=%b", cyc, {Tm, done, busy},
                     {exp_tm(), m_done, exp_busy()});
         end
      end
      n_vec++;
      if (hi !== 12 || dn !== 1) begin
         n_err++;
         $display("FAIL oneshot_len tm_clks=%0d done=%0d exp 12/1", hi, dn);
      end
      ce = 0;
   endtask

   task automatic test_periodic();
      logic [4:0] pat;
      pat = 5'b11000;
      clear_inputs();
      set_ch(1, 2, 3, 1);
      ce = 1;
      st[1] = 1; step(); st = '0;
      for (int i = 0; i < 10; i++) begin
         step();
         n_vec++;
         if (Tm[1] !== pat[4 - (i % 5)] ||
             {Tm, done, busy} !== {exp_tm(), m_done, exp_busy()}) begin
            n_err++;
            $display("FAIL periodic c%0d got=%b exp_tm1=%b", i,
                     {Tm, done, busy}, pat[4 - (i % 5)]);
         end
      end
      abort[1] = 1; step(); abort = '0;
      n_vec++;
      if ({Tm, done, busy} !== '0) begin
         n_err++;
         $display("FAIL periodic_abort got=%b exp=0", {Tm, done, busy});
      end
      ce = 0;
   endtask

   task automatic test_edge();
      clear_inputs();
      set_ch(2, 0, 0, 0);
      st[2] = 1; step(); st = '0;
      n_vec++;
      if (done !== 4'b0100 || Tm !== '0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL len0_pulse done=%b tm=%b busy=%b exp 0100/0000/0",
                  done, Tm, busy);
      end
      step();
      n_vec++;
      if (done !== '0) begin
         n_err++;
         $display("FAIL len0_width done=%b exp 0000", done);
      end
      set_ch(3, 255, 0, 1);
      ce = 1;
      st[3] = 1; step(); st = '0;
      for (int i = 0; i < 600; i++) begin
         step();
         n_vec++;
         if (Tm[3] !== 1'b1 ||
             {Tm, done, busy} !== {exp_tm(), m_done, exp_busy()}) begin
            n_err++;
            $display("FAIL len255_gap0 c%0d got=%b exp_tm3=1", i,
                     {Tm, done, busy});
         end
      end
      abort[3] = 1; step(); abort = '0;
      n_vec++;
      if ({Tm, done, busy} !== '0) begin
         n_err++;
         $display("FAIL len255_abort got=%b exp=0", {Tm, done, busy});
      end
      ce = 0;
   endtask

   task automatic test_parallel();
      int nce, d0, d3;
      clear_inputs();
      nce = 0; d0 = -1; d3 = -1;
      set_ch(0, 4, 0, 0);
      set_ch(3, 6, 0, 0);
      st = 4'b1001; step(); st = '0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         ce = (cyc % 2 == 1);
         step();
         if (ce) nce++;
         if (done[0]) d0 = nce;
         if (done[3]) d3 = nce;
         n_vec++;
         if ({Tm, done, busy} !== {exp_tm(), m_done, exp_busy()}) begin
            n_err++;
            $display("FAIL parallel c%0d got=%b exp=%b", cyc, {Tm, done, busy},
                     {exp_tm(), m_done, exp_busy()});
         end
      end
      n_vec++;
      if (d0 !== 5 || d3 !== 7) begin
         n_err++;
         $display("FAIL parallel_done ce_at_done0=%0d done3=%0d exp 5/7", d0, d3);
      end
      ce = 0;
   endtask

   task automatic test_retrig();
      int hi, dn;
      clear_inputs();
      hi = 0; dn = 0;
      ce = 1;
      for (int i = 0; i < 12; i++) begin
         set_ch(0, (i >= 4) ? 2 : 5, 0, 0);
         st[0] = (i == 0 || i == 4);
         step();
         hi += int'(Tm[0]);
         dn += int'(done[0]);
         n_vec++;
         if ({Tm, done, busy} !== {exp_tm(), m_done, exp_busy()}) begin
            n_err++;
            $display("FAIL retrig c%0d got=%b exp=%b", i, {Tm, done, busy},
                     {exp_tm(), m_done, exp_busy()});
         end
      end
      st = '0;
      n_vec++;
      if (hi !== 5 || dn !== 1) begin
         n_err++;
         $display("FAIL retrig_total tm_ticks=%0d done=%0d exp 5/1", hi, dn);
      end
      ce = 0;
   endtask

   task automatic test_random();
      clear_inputs();
      for (int i = 0; i < 1500; i++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         ce    = ($urandom_range(0, 2) != 0);
         for (int c = 0; c < NCH; c++) begin
            st[c]    = ($urandom_range(0, 11) == 0);
            abort[c] = ($urandom_range(0, 49) == 0);
            set_ch(c, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
         end
         step();
         n_vec++;
         if ({Tm, done, busy} !== {exp_tm(), m_done, exp_busy()}) begin
            n_err++;
            $display("FAIL random c%0d got=%b exp=%b", i, {Tm, done, busy},
                     {exp_tm(), m_done, exp_busy()});
         end
      end
      rst_n = 1;
      clear_inputs();
   endtask

   initial begin
      rst_n = 0;
      clear_inputs();
      test_reset();
      test_oneshot();
      test_periodic();
      test_edge();
      test_parallel();
      test_retrig();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
